simon_block_packer: RTL
=======================

SIMON_BLOCK_PACKER -- requirements
Module: simon_block_packer

Interface
REQ-001 The block SHALL have parameter BLOCK_BYTES, default 8, giving bytes per cipher block (Simon 64-bit block).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving idle cycles before a partial block is flushed (range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port fifo_dout, input, 8 bits: byte-FIFO read data, valid the cycle after fifo_rd_en.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: byte-FIFO empty flag.
REQ-007 The block SHALL have port fifo_rd_en, output, 1 bit: byte-FIFO read strobe.
REQ-008 The block SHALL have port blk_data, output, BLOCK_BYTES*8 bits: assembled block, first byte in the MSB byte.
REQ-009 The block SHALL have port blk_valid, output, 1 bit: blk_data, blk_nbytes and blk_pad are valid.
REQ-010 The block SHALL have port blk_ready, input, 1 bit: the cipher core accepts the block.
REQ-011 The block SHALL have port blk_nbytes, output, $clog2(BLOCK_BYTES+1) bits: count of real (non-pad) bytes.
REQ-012 The block SHALL have port blk_pad, output, 1 bit: the block was zero-padded by timeout.
REQ-013 The block SHALL have port busy, output, 1 bit: a partial block is held or a FIFO read is in flight.

Function
REQ-014 The FSM SHALL have two states: FILL (gather bytes) and OUT (present block).
REQ-015 In FILL, fifo_rd_en SHALL be 1 iff fifo_empty=0 and (byte_cnt + rd_pending) < BLOCK_BYTES; combinational.
REQ-016 fifo_rd_en SHALL never be 1 while fifo_empty=1, in state OUT, or while rst=0.
REQ-017 rd_pending SHALL register fifo_rd_en; when rd_pending=1, fifo_dout SHALL be written to byte slot byte_cnt (slot 0 = MSB), and byte_cnt SHALL increment.
REQ-018 When the capture brings byte_cnt to BLOCK_BYTES, the FSM SHALL move to OUT; blk_valid SHALL be 1 from the next cycle.
REQ-019 With the FIFO continuously non-empty, fifo_rd_en SHALL be high in cycles 0..7 and blk_valid high from cycle 9 (BLOCK_BYTES=8).
REQ-020 In OUT, blk_valid, blk_data, blk_nbytes and blk_pad SHALL hold stable until blk_ready=1.
REQ-021 On a blk_valid&&blk_ready cycle, the FSM SHALL return to FILL, clear byte_cnt, blk_data and blk_pad, and deassert blk_valid next cycle; fifo_rd_en may assert in that following cycle.
REQ-022 busy SHALL equal (state==OUT) | (byte_cnt!=0) | rd_pending.

Reset
REQ-023 With rst=0 at a clk edge: state=FILL, byte_cnt=0, rd_pending=0, timer=0, blk_data=0, blk_valid=0, blk_nbytes=0, blk_pad=0, busy=0.
REQ-024 Reset mid-fill or mid-OUT SHALL discard the partial or held block; a byte returned by a read in flight SHALL be dropped, not captured.

Configuration
REQ-025 The macro SIMON_PACKER_TIMEOUT_EN SHALL compile in the idle-flush feature.
REQ-026 With SIMON_PACKER_TIMEOUT_EN, in FILL with byte_cnt>0, rd_pending=0 and fifo_empty=1, the timer SHALL increment each cycle; on any capture, or with byte_cnt=0, it SHALL clear.
REQ-027 When the timer reaches TIMEOUT_CYCLES, the block SHALL enter OUT with the unfilled slots zero, blk_nbytes=byte_cnt and blk_pad=1.
REQ-028 If fifo_empty=0 in the cycle the timer would expire, the read SHALL take priority and the timer SHALL clear.
REQ-029 Without SIMON_PACKER_TIMEOUT_EN, there SHALL be no timer logic, blk_pad SHALL be tied 0, and a partial block SHALL wait in FILL indefinitely.

Structure
REQ-030 simon_pkg SHALL hold the packer_state_t enum (FILL, OUT) and the default constants SIMON_BLOCK_BYTES=8 and SIMON_TIMEOUT_CYCLES=255.
REQ-031 The idle timer SHALL be the sub-module simon_idle_timer (inputs: count enable and clear; output: expired), instantiated only under SIMON_PACKER_TIMEOUT_EN.

Verification
REQ-032 Full block: bytes 01..08 pushed, blk_ready=1 -> blk_data=0x0102030405060708, blk_nbytes=8, blk_pad=0, one blk_valid cycle.
REQ-033 Backpressure: 16 bytes pushed, blk_ready=0 for 20 cycles -> first block held stable and fifo_rd_en=0 throughout OUT; after ready, second block 0x090A..10 follows.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=10): bytes AA BB CC then FIFO empty -> after 10 idle cycles, blk_data=0xAABBCC0000000000, blk_nbytes=3, blk_pad=1.
REQ-035 Timeout race: byte 4 arrives (fifo_empty falls) in the expiry cycle -> no flush, byte captured, timer restarts.
REQ-036 Reset mid-fill: rst=0 after 5 bytes captured and one read in flight -> all outputs reset; the next 8 bytes form a clean block, and the dropped byte does not appear in it.
REQ-037 Assertion: fifo_rd_en&&fifo_empty is never true in any test.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and default constants for the Simon block packer.
package simon_pkg;

  // Packer FSM: gather bytes, then present the assembled block
  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } packer_state_t;

  localparam int SIMON_BLOCK_BYTES    = 8;
  localparam int SIMON_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/simon_idle_timer.sv
// Idle counter for the packer's partial-block flush. Counts while en is
// high, returns to zero on clr, and flags expired once LIMIT is reached.
module simon_idle_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,      // synchronous, active-low
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [15:0] count_q, count_d;

  assign expired = (count_q == 16'(LIMIT));

  // Next count: clear wins, otherwise advance until the limit is hit
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/simon_block_packer.sv
// Packs bytes from a byte FIFO into BLOCK_BYTES-wide cipher blocks,
// first byte in the MSB byte. Optional idle flush of a partial block is
// compiled in with the macro SIMON_PACKER_TIMEOUT_EN; without it a
// partial block waits in FILL until the remaining bytes arrive.
module simon_block_packer
  import simon_pkg::*;
#(
  parameter int BLOCK_BYTES    = SIMON_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = SIMON_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,        // synchronous, active-low
  input  logic [7:0]                       fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic [BLOCK_BYTES*8-1:0]         blk_data,
  output logic                             blk_valid,
  input  logic                             blk_ready,
  output logic [$clog2(BLOCK_BYTES+1)-1:0] blk_nbytes,
  output logic                             blk_pad,
  output logic                             busy
);

  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int DW = BLOCK_BYTES * 8;

  packer_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pending_q, rd_pending_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] nbytes_q, nbytes_d;
  logic [CW:0]   inflight;
  logic          flush;

  // Bytes already captured plus the one still on its way from the FIFO
  assign inflight = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pending_q};

`ifdef SIMON_PACKER_TIMEOUT_EN
  logic pad_q, pad_d;
  logic count_en;
  logic timer_clr;
  logic expired;

  // Idle means: partial block held, nothing in flight, nothing to read.
  // A non-empty FIFO in the expiry cycle therefore clears the timer and
  // lets the read win.
  assign count_en  = (state_q == FILL) && (cnt_q != '0) && !rd_pending_q && fifo_empty;
  assign timer_clr = !count_en;
  assign flush     = count_en && expired;

  simon_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (count_en),
    .clr    (timer_clr),
    .expired(expired)
  );

  assign blk_pad = pad_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign flush              = 1'b0;
  assign blk_pad            = 1'b0;
`endif

  assign blk_data   = data_q;
  assign blk_nbytes = nbytes_q;
  assign blk_valid  = (state_q == OUT);
  assign busy       = (state_q == OUT) || (cnt_q != '0) || rd_pending_q;

  // Next-state, byte capture and the combinational FIFO read strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    fifo_rd_en = 1'b0;
`ifdef SIMON_PACKER_TIMEOUT_EN
    pad_d      = pad_q;
`endif
    case (state_q)
      FILL: begin
        fifo_rd_en = rst && !fifo_empty && (inflight < (CW + 1)'(BLOCK_BYTES));
        if (rd_pending_q) begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (cnt_q == CW'(i)) begin
              data_d[(BLOCK_BYTES - 1 - i) * 8 +: 8] = fifo_dout;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
            state_d  = OUT;
            nbytes_d = CW'(BLOCK_BYTES);
          end
        end else if (flush) begin
          // Unfilled slots are still zero from the last clear
          state_d  = OUT;
          nbytes_d = cnt_q;
`ifdef SIMON_PACKER_TIMEOUT_EN
          pad_d    = 1'b1;
`endif
        end
      end
      OUT: begin
        if (blk_ready) begin
          state_d  = FILL;
          cnt_d    = '0;
          data_d   = '0;
          nbytes_d = '0;
`ifdef SIMON_PACKER_TIMEOUT_EN
          pad_d    = 1'b0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
    rd_pending_d = fifo_rd_en;
  end

  // State registers; reset drops any held block and any byte in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      data_q       <= '0;
      nbytes_q     <= '0;
`ifdef SIMON_PACKER_TIMEOUT_EN
      pad_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= rd_pending_d;
      data_q       <= data_d;
      nbytes_q     <= nbytes_d;
`ifdef SIMON_PACKER_TIMEOUT_EN
      pad_q        <= pad_d;
`endif
    end
  end

endmodule
